fir_tdm: RTL and testbench

FIR_TDM -- requirements
Module: fir_tdm

---
 rtl/fir_tdm.sv | 131 +++++++++++++
 tb/tb_fir_tdm.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tdm.sv
// Time-multiplexed multichannel FIR: one shared MAC walks every tap of every channel
// per input sample, then rounds, saturates and publishes all channels together.
module fir_tdm #(
    parameter int W     = 16,
    parameter int CH    = 2,
    parameter int TAPS  = 8,
    parameter int CW    = 16,
    parameter int SHIFT = 15
) (
    input  logic                    ck,
    input  logic                    rst,
    input  logic [CH*W-1:0]         in,
    input  logic                    input_ready,
    input  logic                    bypass,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [CW-1:0]           coef_data,
    output logic [CH*W-1:0]         out,
    output logic                    output_ready,
    output logic                    busy,
    output logic                    overrun
);
    localparam int TW  = $clog2(TAPS);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
    localparam int AW  = W + CW + TW;

    localparam logic [TW-1:0]         TAP_LAST = TW'(TAPS - 1);
    localparam logic [CHW-1:0]        CH_LAST  = CHW'(CH - 1);
    localparam logic signed [CW-1:0]  COEF_ONE = {1'b0, {(CW-1){1'b1}}};
    localparam logic signed [AW-1:0]  RND      = AW'(1) << (SHIFT - 1);
    localparam logic signed [AW-1:0]  SMAX     = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0]  SMIN     = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, ROUND, DONE} state_t;

    state_t                 state, next;
    logic [TW-1:0]          tap;
    logic [CHW-1:0]         ch;
    logic                   byp;
    logic                   accept;
    logic signed [W-1:0]    x [CH][TAPS];
    logic signed [CW-1:0]   coef [TAPS];
    logic signed [W-1:0]    shadow [CH];
    logic signed [AW-1:0]   acc, acc_base, prod;
    logic signed [W-1:0]    rval;

    // Round half up, arithmetic shift, clamp to the signed sample range.
    function automatic logic signed [W-1:0] round_sat(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] r;
        r = (v + RND) >>> SHIFT;
        if (r > SMAX) return SMAX[W-1:0];
        if (r < SMIN) return SMIN[W-1:0];
        return r[W-1:0];
    endfunction

    assign accept       = (state == IDLE) && input_ready;
    assign output_ready = (state == DONE);
    assign busy         = (state != IDLE);

    always_ff @(posedge ck) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (input_ready) next = MAC;
            MAC:     if (tap == TAP_LAST) next = ROUND;
            ROUND:   next = (ch == CH_LAST) ? DONE : MAC;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        prod     = AW'(coef[tap]) * AW'(x[ch][tap]);
        acc_base = (tap == '0) ? '0 : acc;
        rval     = byp ? x[ch][0] : round_sat(acc);
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            tap     <= '0;
            ch      <= '0;
            byp     <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (input_ready && state != IDLE) overrun <= 1'b1;
            if (accept) byp <= bypass;
            case (state)
                IDLE: begin
                    tap <= '0;
                    ch  <= '0;
                end
                MAC:     tap <= (tap == TAP_LAST) ? '0 : tap + 1'b1;
                ROUND:   ch  <= ch + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            acc <= '0;
            out <= '0;
            for (int c = 0; c < CH; c++) begin
                shadow[c] <= '0;
                for (int k = 0; k < TAPS; k++) x[c][k] <= '0;
            end
            for (int k = 0; k < TAPS; k++) coef[k] <= (k == 0) ? COEF_ONE : '0;
        end else begin
            if (coef_we && state == IDLE) coef[coef_addr] <= coef_data;
            if (accept) begin
                for (int c = 0; c < CH; c++) begin
                    x[c][0] <= in[c*W +: W];
                    for (int k = 1; k < TAPS; k++) x[c][k] <= x[c][k-1];
                end
            end
            if (state == MAC) acc <= acc_base + prod;
            if (state == ROUND) begin
                shadow[ch] <= rval;
                // The last channel's result bypasses its shadow so all channels land on out together.
                if (ch == CH_LAST) begin
                    for (int c = 0; c < CH; c++)
                        out[c*W +: W] <= (CHW'(c) == ch) ? rval : shadow[c];
                end
            end
        end
    end
endmodule

// File: tb/tb_fir_tdm.sv
// Randomized scoreboard bench for fir_tdm against a plain-arithmetic convolution model.
module tb_fir_tdm;
    localparam int W     = 16;
    localparam int CH    = 2;
    localparam int TAPS  = 8;
    localparam int CW    = 16;
    localparam int SHIFT = 15;
    localparam int AD    = $clog2(TAPS);
    localparam int L     = CH * (TAPS + 1) + 1;

    logic            ck = 1'b0;
    logic            rst;
    logic [CH*W-1:0] in;
    logic            input_ready, bypass, coef_we;
    logic [AD-1:0]   coef_addr;
    logic [CW-1:0]   coef_data;
    logic [CH*W-1:0] out;
    logic            output_ready, busy, overrun;

    fir_tdm #(.W(W), .CH(CH), .TAPS(TAPS), .CW(CW), .SHIFT(SHIFT)) dut (
        .ck(ck), .rst(rst), .in(in), .input_ready(input_ready), .bypass(bypass),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out(out), .output_ready(output_ready), .busy(busy), .overrun(overrun)
    );

    always #5 ck = ~ck;

    int cyc = 0;
    always @(posedge ck) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [CH*W-1:0] val;
        int              cyc;
    } exp_t;
    exp_t sbq[$];

    longint          hist [CH][TAPS];
    longint          cf [TAPS];
    logic [CH*W-1:0] hold_ref = '0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic void model_reset();
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < TAPS; k++) hist[c][k] = 0;
        for (int k = 0; k < TAPS; k++) cf[k] = 0;
        cf[0] = 2**(CW-1) - 1;
    endfunction

    function automatic longint model_out(input int c);
        longint s, r;
        s = 0;
        for (int k = 0; k < TAPS; k++) s += cf[k] * hist[c][k];
        r = (s + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
        if (r > 2**(W-1) - 1) r = 2**(W-1) - 1;
        if (r < -(2**(W-1))) r = -(2**(W-1));
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge ck);
            #1;
        end
    endtask

    task automatic send(input longint s0, input longint s1, input bit byp, input bit we,
                        input int addr, input longint data, input bit push);
        exp_t   e;
        longint s [CH];
        longint v;
        s[0] = s0;
        s[1] = s1;
        for (int c = 0; c < CH; c++) in[c*W +: W] = W'(s[c]);
        bypass      = byp;
        input_ready = 1'b1;
        coef_we     = we;
        coef_addr   = AD'(addr);
        coef_data   = CW'(data);
        if (we) cf[addr] = data;
        for (int c = 0; c < CH; c++) begin
            for (int k = TAPS - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
            hist[c][0] = s[c];
        end
        for (int c = 0; c < CH; c++) begin
            v = byp ? s[c] : model_out(c);
            e.val[c*W +: W] = W'(v);
        end
        e.cyc = cyc + L;
        if (push) sbq.push_back(e);
        tick(1);
        input_ready = 1'b0;
        coef_we     = 1'b0;
        bypass      = 1'b0;
    endtask

    task automatic write_coef(input int addr, input longint data, input bit idle);
        coef_we   = 1'b1;
        coef_addr = AD'(addr);
        coef_data = CW'(data);
        if (idle) cf[addr] = data;
        tick(1);
        coef_we = 1'b0;
    endtask

    task automatic wait_idle(input int exp_n);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick(1);
            n++;
        end
        if (n >= 200) check("idle_timeout", n, 0);
        else if (exp_n >= 0) check("busy_cycles", n, exp_n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        model_reset();
    endtask

    function automatic longint ch_out(input int c);
        return longint'($signed(out[c*W +: W]));
    endfunction

    // Monitor: pops the scoreboard on every output pulse, otherwise out must hold.
    always @(negedge ck) begin
        exp_t e;
        if (rst) begin
            hold_ref = '0;
        end else if (output_ready) begin
            if (sbq.size() == 0) begin
                check("unexpected_output_ready", 1, 0);
            end else begin
                e = sbq.pop_front();
                check("latency", cyc, e.cyc);
                for (int c = 0; c < CH; c++)
                    check($sformatf("out_ch%0d", c), ch_out(c),
                          longint'($signed(e.val[c*W +: W])));
                hold_ref = e.val;
            end
        end else begin
            check("out_hold", longint'(out), longint'(hold_ref));
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in = '0; input_ready = 1'b0; bypass = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        model_reset();
        tick(2);
        rst = 1'b0;
        check("rst_out", longint'(out), 0);
        check("rst_output_ready", longint'(output_ready), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_overrun", longint'(overrun), 0);

        // Identity with the reset coefficient set.
        send(1000, -1000, 0, 0, 0, 0, 1);
        wait_idle(L);
        check("identity_ch0", ch_out(0), 1000);
        check("identity_ch1", ch_out(1), -1000);

        // Moving average ramp.
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, 4096, 1);
        for (int i = 1; i <= 8; i++) begin
            send(8000, 8000, 0, 0, 0, 0, 1);
            wait_idle(-1);
            check("avg_ch0", ch_out(0), 1000 * i);
        end

        // Saturation both directions.
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, 32767, 1);
        for (int i = 0; i < 8; i++) begin
            send(32767, 32767, 0, 0, 0, 0, 1);
            wait_idle(-1);
        end
        check("sat_pos", ch_out(0), 32767);
        for (int i = 0; i < 8; i++) begin
            send(-32768, -32768, 0, 0, 0, 0, 1);
            wait_idle(-1);
        end
        check("sat_neg", ch_out(1), -32768);

        // Bypass with a zero filter.
        do_reset();
        write_coef(0, 0, 1);
        send(1234, -77, 1, 0, 0, 0, 1);
        wait_idle(-1);
        check("bypass_ch0", ch_out(0), 1234);

        // Coefficient write coincident with acceptance applies to that sample.
        do_reset();
        send(1000, 1000, 0, 1, 0, 16384, 1);
        wait_idle(-1);
        check("write_and_accept", ch_out(0), 500);

        // Coefficient write while busy is ignored.
        do_reset();
        send(1000, -1000, 0, 0, 0, 0, 1);
        write_coef(0, 100, 0);
        wait_idle(-1);
        send(2000, 2000, 0, 0, 0, 0, 1);
        wait_idle(-1);
        check("busy_write_ignored", ch_out(0), 2000);

        // Overrun: second pulse five cycles later is dropped.
        do_reset();
        check("overrun_clear", longint'(overrun), 0);
        write_coef(0, 16384, 1);
        write_coef(1, 16384, 1);
        send(500, 500, 0, 0, 0, 0, 1);
        tick(4);
        in = {W'(7777), W'(7777)};
        input_ready = 1'b1;
        tick(1);
        input_ready = 1'b0;
        wait_idle(-1);
        check("overrun_set", longint'(overrun), 1);
        send(100, 100, 0, 0, 0, 0, 1);
        wait_idle(-1);
        check("overrun_dropped", ch_out(0), 300);
        check("overrun_sticky", longint'(overrun), 1);

        // Abort mid-computation.
        do_reset();
        write_coef(0, 5, 1);
        send(1000, 1000, 0, 0, 0, 0, 0);
        tick(9);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        model_reset();
        tick(25);
        check("abort_busy", longint'(busy), 0);
        check("abort_out", longint'(out), 0);
        send(1000, -1000, 0, 0, 0, 0, 1);
        wait_idle(-1);
        check("abort_coef0_restored", ch_out(0), 1000);

        // Randomized traffic.
        do_reset();
        for (int it = 0; it < 40; it++) begin
            bit     byp, we;
            int     addr;
            longint s0, s1, d;
            if ($urandom_range(0, 2) == 0)
                write_coef($urandom_range(0, TAPS - 1), longint'($urandom_range(0, 32767)) - 16384, 1);
            s0   = longint'($urandom_range(0, 65535)) - 32768;
            s1   = longint'($urandom_range(0, 65535)) - 32768;
            byp  = ($urandom_range(0, 4) == 0);
            we   = ($urandom_range(0, 4) == 0);
            addr = $urandom_range(0, TAPS - 1);
            d    = longint'($urandom_range(0, 32767)) - 16384;
            send(s0, s1, byp, we, addr, d, 1);
            if ($urandom_range(0, 3) == 0)
                write_coef($urandom_range(0, TAPS - 1), longint'($urandom_range(0, 65535)) - 32768, 0);
            wait_idle(-1);
            tick($urandom_range(0, 2));
        end

        tick(3);
        check("scoreboard_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
